// File: rtl/cond_writeback_stage.sv
// Condition-evaluation / writeback stage: owns the NZCV flags, gates the write strobes
// by the instruction's ARM condition and holds the result in a one-entry valid/ready buffer.
module cond_writeback_stage #(
  parameter int         DATA_W    = 32,
  parameter int         REG_AW    = 4,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Cond,
  input  logic [1:0]        FlagW,
  input  logic [3:0]        ALUFlags,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [REG_AW-1:0] Rd,
  input  logic              RegW,
  input  logic              MemW,
  input  logic              PCS,
  input  logic              NoWrite,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] WA3,
  output logic [DATA_W-1:0] WD3,
  output logic [DATA_W-1:0] WDmem,
  output logic              RegWrite,
  output logic              MemWrite,
  output logic              PCSrc,
  output logic              CondExQ,
  output logic [3:0]        Flags
);

  logic              r_valid;
  logic [REG_AW-1:0] r_wa3;
  logic [DATA_W-1:0] r_wd3;
  logic [DATA_W-1:0] r_wdmem;
  logic              r_reg_write;
  logic              r_mem_write;
  logic              r_pc_src;
  logic              r_cond_ex;
  logic [3:0]        r_flags;

  logic w_n, w_z, w_c, w_v;
  logic w_base;
  logic w_cond_ex;
  logic w_accept;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  assign in_ready = ~r_valid | wb_ready;
  assign w_accept = in_valid & in_ready;

  // Conditions come in true/inverted pairs: Cond[3:1] picks the predicate, Cond[0] inverts it.
  always_comb begin
    // NOTE: w_base gets a default before the case so no path leaves it unassigned (no latch).
    w_base = 1'b1;
    case (Cond[3:1])
      3'd0:    w_base = w_z;
      3'd1:    w_base = w_c;
      3'd2:    w_base = w_n;
      3'd3:    w_base = w_v;
      3'd4:    w_base = w_c & ~w_z;
      3'd5:    w_base = (w_n == w_v);
      3'd6:    w_base = ~w_z & (w_n == w_v);
      default: w_base = 1'b1;
    endcase
    // AL and the 1111 encoding both execute unconditionally.
    w_cond_ex = (Cond[3:1] == 3'b111) ? 1'b1 : (w_base ^ Cond[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      r_valid     <= 1'b0;
      r_wa3       <= '0;
      r_wd3       <= '0;
      r_wdmem     <= '0;
      r_reg_write <= 1'b0;
      r_mem_write <= 1'b0;
      r_pc_src    <= 1'b0;
      r_cond_ex   <= 1'b0;
      r_flags     <= FLAGS_RST;
    end else if (w_accept) begin
      r_valid     <= 1'b1;
      r_wa3       <= Rd;
      r_wd3       <= ALUResult;
      r_wdmem     <= StoreData;
      r_reg_write <= RegW & w_cond_ex & ~NoWrite;
      r_mem_write <= MemW & w_cond_ex;
      r_pc_src    <= PCS & w_cond_ex;
      r_cond_ex   <= w_cond_ex;
      if (FlagW[1] && w_cond_ex) r_flags[3:2] <= ALUFlags[3:2];
      if (FlagW[0] && w_cond_ex) r_flags[1:0] <= ALUFlags[1:0];
    end else if (wb_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign wb_valid = r_valid;
  assign WA3      = r_wa3;
  assign WD3      = r_wd3;
  assign WDmem    = r_wdmem;
  assign RegWrite = r_reg_write;
  assign MemWrite = r_mem_write;
  assign PCSrc    = r_pc_src;
  assign CondExQ  = r_cond_ex;
  assign Flags    = r_flags;

endmodule

// File: tb/tb_cond_writeback_stage.sv
// Self-checking bench for cond_writeback_stage: directed table, hand sequences,
// full condition sweep and random traffic against a behavioural model.
module tb_cond_writeback_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        Cond;
  logic [1:0]        FlagW;
  logic [3:0]        ALUFlags;
  logic [DATA_W-1:0] ALUResult;
  logic [DATA_W-1:0] StoreData;
  logic [REG_AW-1:0] Rd;
  logic              RegW, MemW, PCS, NoWrite;
  logic              wb_valid;
  logic              wb_ready;
  logic [REG_AW-1:0] WA3;
  logic [DATA_W-1:0] WD3;
  logic [DATA_W-1:0] WDmem;
  logic              RegWrite, MemWrite, PCSrc, CondExQ;
  logic [3:0]        Flags;

  cond_writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FLAGS_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Cond(Cond), .FlagW(FlagW), .ALUFlags(ALUFlags), .ALUResult(ALUResult),
    .StoreData(StoreData), .Rd(Rd), .RegW(RegW), .MemW(MemW), .PCS(PCS),
    .NoWrite(NoWrite), .wb_valid(wb_valid), .wb_ready(wb_ready), .WA3(WA3),
    .WD3(WD3), .WDmem(WDmem), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .PCSrc(PCSrc), .CondExQ(CondExQ), .Flags(Flags)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model of the architectural state.
  logic              m_valid;
  logic [REG_AW-1:0] m_wa3;
  logic [DATA_W-1:0] m_wd3, m_wdmem;
  logic              m_rw, m_mw, m_pc, m_ce;
  logic [3:0]        m_flags;

  typedef struct {
    logic [3:0] init_flags;
    logic [3:0] cond;
    logic [1:0] flagw;
    logic [3:0] aluflags;
    logic       regw, memw, pcs, nowrite;
    logic       exp_rw, exp_mw, exp_pc, exp_ce;
    logic [3:0] exp_flags;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Truth of each ARM condition, straight from the architectural definition.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wa3 = '0; m_wd3 = '0; m_wdmem = '0;
    m_rw = 0; m_mw = 0; m_pc = 0; m_ce = 0; m_flags = 4'b0000;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
    check({tag, ".WA3"},      32'(WA3),      32'(m_wa3));
    check({tag, ".WD3"},      WD3,           m_wd3);
    check({tag, ".WDmem"},    WDmem,         m_wdmem);
    check({tag, ".RegWrite"}, 32'(RegWrite), 32'(m_rw));
    check({tag, ".MemWrite"}, 32'(MemWrite), 32'(m_mw));
    check({tag, ".PCSrc"},    32'(PCSrc),    32'(m_pc));
    check({tag, ".CondExQ"},  32'(CondExQ),  32'(m_ce));
    check({tag, ".Flags"},    32'(Flags),    32'(m_flags));
  endtask

  // One clock: check in_ready, predict the edge, advance, check all outputs.
  task automatic step(input string tag);
    logic ready, acc, ce;
    #1;
    ready = !m_valid || wb_ready;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(ready));
    acc = in_valid && ready;
    ce  = cond_holds(Cond, m_flags);
    @(posedge clk);
    #1;
    if (acc) begin
      m_valid = 1; m_wa3 = Rd; m_wd3 = ALUResult; m_wdmem = StoreData;
      m_rw = RegW && ce && !NoWrite;
      m_mw = MemW && ce;
      m_pc = PCS && ce;
      m_ce = ce;
      if (FlagW[1] && ce) m_flags[3:2] = ALUFlags[3:2];
      if (FlagW[0] && ce) m_flags[1:0] = ALUFlags[1:0];
    end else if (wb_ready) begin
      m_valid = 0;
    end
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic rw, input logic mw,
                       input logic pc, input logic nw);
    in_valid = v; Cond = c; FlagW = fw; ALUFlags = af;
    RegW = rw; MemW = mw; PCS = pc; NoWrite = nw;
    ALUResult = $urandom; StoreData = $urandom; Rd = REG_AW'($urandom);
  endtask

  // Unconditional flag-setting instruction used to preload NZCV.
  task automatic set_flags(input logic [3:0] f);
    drive(1, 4'hE, 2'b11, f, 0, 0, 0, 1);
  endtask

  initial begin
    tbl[0] = '{4'b0000, 4'hE, 2'b11, 4'b0100, 0, 0, 0, 1,  0, 0, 0, 1, 4'b0100}; // CMP
    tbl[1] = '{4'b0100, 4'h0, 2'b00, 4'b0000, 0, 0, 1, 0,  0, 0, 1, 1, 4'b0100}; // BEQ taken
    tbl[2] = '{4'b0100, 4'h1, 2'b00, 4'b0000, 0, 0, 1, 0,  0, 0, 0, 0, 4'b0100}; // BNE not taken
    tbl[3] = '{4'b1000, 4'h5, 2'b11, 4'b0010, 1, 0, 0, 0,  0, 0, 0, 0, 4'b1000}; // PL fails
    tbl[4] = '{4'b0000, 4'hE, 2'b11, 4'b1011, 1, 0, 0, 1,  0, 0, 0, 1, 4'b1011}; // NoWrite
    tbl[5] = '{4'b0010, 4'h8, 2'b01, 4'b0101, 1, 1, 0, 0,  1, 1, 0, 1, 4'b0001}; // HI, C/V only
    tbl[6] = '{4'b1000, 4'hC, 2'b00, 4'b0000, 0, 1, 0, 0,  0, 0, 0, 0, 4'b1000}; // GT fails
    tbl[7] = '{4'b0000, 4'hF, 2'b00, 4'b0000, 1, 0, 1, 0,  1, 0, 1, 1, 4'b0000}; // 1111 = always

    rst_n = 0; wb_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_outputs("reset");
    #20;
    @(posedge clk); #1;
    rst_n = 1;

    // Directed table: preload flags, then the instruction back-to-back.
    wb_ready = 1;
    for (int i = 0; i < 8; i++) begin
      set_flags(tbl[i].init_flags);
      step($sformatf("tbl%0d.pre", i));
      drive(1, tbl[i].cond, tbl[i].flagw, tbl[i].aluflags,
            tbl[i].regw, tbl[i].memw, tbl[i].pcs, tbl[i].nowrite);
      step($sformatf("tbl%0d", i));
      check($sformatf("tbl%0d.exp_RegWrite", i), 32'(RegWrite), 32'(tbl[i].exp_rw));
      check($sformatf("tbl%0d.exp_MemWrite", i), 32'(MemWrite), 32'(tbl[i].exp_mw));
      check($sformatf("tbl%0d.exp_PCSrc", i),    32'(PCSrc),    32'(tbl[i].exp_pc));
      check($sformatf("tbl%0d.exp_CondExQ", i),  32'(CondExQ),  32'(tbl[i].exp_ce));
      check($sformatf("tbl%0d.exp_Flags", i),    32'(Flags),    32'(tbl[i].exp_flags));
      check($sformatf("tbl%0d.exp_wb_valid", i), 32'(wb_valid), 32'd1);
    end

    // Backpressure: hold for 5 cycles, then release with no bubble.
    begin
      logic [DATA_W-1:0] held_wd3, new_wd3;
      wb_ready = 0;
      drive(1, 4'hE, 2'b00, 4'b0000, 1, 0, 0, 0);
      step("bp.load");
      held_wd3 = m_wd3;
      drive(1, 4'hE, 2'b00, 4'b0000, 1, 1, 1, 0);
      new_wd3 = ALUResult;
      for (int k = 0; k < 5; k++) begin
        step($sformatf("bp.hold%0d", k));
        check("bp.held_WD3", WD3, held_wd3);
      end
      wb_ready = 1;
      step("bp.release");
      check("bp.new_WD3", WD3, new_wd3);
      check("bp.no_bubble", 32'(wb_valid), 32'd1);
    end

    // Stale inputs with in_valid low and buffer stalled: nothing changes.
    wb_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 4'($urandom), 2'b11, 4'($urandom), 1, 1, 1, 0);
      step("stale");
    end

    // Reset mid-stall takes effect before any edge.
    set_flags(4'b1111);
    wb_ready = 1;
    step("rst.pre1");
    wb_ready = 0;
    drive(1, 4'hE, 2'b00, 4'b0000, 1, 1, 1, 0);
    step("rst.pre2");
    #3;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs("rst.async");
    check("rst.in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Full sweep: every condition against every NZCV value.
    wb_ready = 1;
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        set_flags(4'(f));
        step("sweep.pre");
        drive(1, 4'(c), 2'b00, 4'b0000, 1, 1, 1, 0);
        step($sformatf("sweep.c%0h.f%0h", c, f));
      end
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      wb_ready = 1'($urandom_range(0, 2) != 0);
      step($sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
